bus_interface_unit: RTL and testbench
=====================================

BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: consecutive WAIT cycles without DTACK/BERR before a timeout bus error.
REQ-002 SHALL have parameter ADDR_W, default 24: byte-address width; the A output is [ADDR_W-1:1].
REQ-003 SHALL have port CLK  in  1: clock; all logic on the rising edge.
REQ-004 SHALL have port RESET  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port req  in  1: core request; sampled only in IDLE.
REQ-006 SHALL have port req_rw  in  1: 1 = read, 0 = write.
REQ-007 SHALL have port req_size  in  2: 00 = byte, 01 = word, 10 = long; 11 is treated as word.
REQ-008 SHALL have port req_addr  in  24: byte address.
REQ-009 SHALL have port req_wdata  in  32: write data; byte in [7:0], word in [15:0].
REQ-010 SHALL have port ack  out  1: one-cycle completion pulse.
REQ-011 SHALL have port err  out  1: high with ack on address error, BERR or timeout.
REQ-012 SHALL have port rdata  out  32: read result, zero-extended, valid while ack is high and held until the next accept.
REQ-013 SHALL have port busy  out  1: high in every state except IDLE.
REQ-014 SHALL have ports A  out  23 (address [23:1]) and D_out  out  16 (write data).
REQ-015 SHALL have ports AS, UDS, LDS  out  1 each: bus strobes, active-high asserted.
REQ-016 SHALL have port RW  out  1: 1 = read, 0 = write.
REQ-017 SHALL have port D_oe  out  1: D_out drive enable.
REQ-018 SHALL have port D_in  in  16: read data from the bus.
REQ-019 SHALL have ports DTACK and BERR  in  1 each: data acknowledge and bus error, active-high.

Function
REQ-020 SHALL implement states IDLE, ADDR, STROBE, WAIT, END.
REQ-021 SHALL transition IDLE->ADDR on req=1 and latch req_rw, req_size, req_addr and req_wdata; req is ignored while busy.
REQ-022 SHALL handle a misaligned word/long request (addr[0]=1) by going IDLE->END with no bus activity and asserting ack+err in that END cycle.
REQ-023 SHALL, in ADDR, drive A from the current address and drive RW; AS, UDS, LDS and D_oe stay low; next state is STROBE.
REQ-024 SHALL, in STROBE and WAIT, assert AS; for word size assert both UDS and LDS; for byte size assert UDS if addr[0]=0, else LDS.
REQ-025 SHALL, for writes, drive D_out and assert D_oe in STROBE, WAIT and END, with the byte replicated to D_out[15:8] and D_out[7:0]; long writes put the high word first.
REQ-026 SHALL move STROBE->WAIT unconditionally; WAIT samples DTACK and BERR every cycle.
REQ-027 SHALL, in WAIT, take BERR=1 (which has priority over DTACK) to END with err set.
REQ-028 SHALL, in WAIT on DTACK=1 (BERR=0) for a read, capture D_in: the byte lane per addr[0], the full word, or the high/low half of a long; then go to END.
REQ-029 SHALL, in WAIT, count cycles; when the count reaches TIMEOUT_CYCLES, go to END with err; the counter clears on entry to WAIT.
REQ-030 SHALL, in END, deassert AS, UDS and LDS.
REQ-031 SHALL, from END on the first half of an error-free long, add 2 to the address (24-bit wrap: 0xFFFFFE->0x000000) and go to ADDR.
REQ-032 SHALL otherwise go from END to IDLE, with ack asserted in that final END cycle.
REQ-033 SHALL abort a long on an error in its first half: no second cycle, ack+err in that END cycle.
REQ-034 SHALL have a minimum latency, with DTACK held high, of 4 edges from the accepting edge to ack for byte/word and 8 edges for long.
REQ-035 SHALL hold RW=1, D_oe=0 and all strobes low in IDLE.

Reset
REQ-036 SHALL, on RESET=1 at any edge (including mid-cycle), move to state IDLE and drive AS, UDS, LDS, D_oe, ack, err and busy to 0.
REQ-037 SHALL, on RESET=1, set RW=1 and set A, D_out, rdata and the timeout counter to 0.
REQ-038 SHALL produce no ack for a cycle aborted by reset.

Verification
REQ-039 SHALL cover a word read: addr 0x000100, DTACK=1, D_in=0xBEEF -> A=0x000080, UDS=LDS=1, ack after 4 edges, rdata=0x0000BEEF, err=0.
REQ-040 SHALL cover a byte write: addr 0x000201, wdata 0x5A, 2 DTACK wait states -> only LDS asserted, D_out=0x5A5A, RW=0, ack after 6 edges.
REQ-041 SHALL cover a long read: addr 0xFFFFFE, words 0x1234 then 0x5678 -> second cycle at A=0, rdata=0x12345678, ack after 8 edges.
REQ-042 SHALL cover BERR and DTACK asserted together in the first half of a long -> ack+err, a single bus cycle only.
REQ-043 SHALL cover a misaligned word (addr 0x000003) -> ack+err with AS never asserted; also no DTACK with TIMEOUT_CYCLES=4 -> err after 4 WAIT cycles.
REQ-044 SHALL cover RESET asserted during WAIT -> next cycle AS=UDS=LDS=D_oe=0, busy=0, no ack.

Source files
------------

// File: rtl/bus_interface_unit.sv
// Bus master bridging single-word core requests onto a 16-bit asynchronous bus.
// Long transfers run as two word cycles, high word first; misaligned requests complete with an error and no bus activity.
module bus_interface_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 24
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ack,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:1] A,
    output logic [15:0]       D_out,
    output logic              AS,
    output logic              UDS,
    output logic              LDS,
    output logic              RW,
    output logic              D_oe,
    input  logic [15:0]       D_in,
    input  logic              DTACK,
    input  logic              BERR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_END    = 3'd4;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [15:0]       wlo_q, wlo_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              byte_q, byte_d;
    logic              long_q, long_d;
    logic              half_q, half_d;
    logic              err_q, err_d;
    logic              misal_q, misal_d;
    logic              req_misal;

    // Word and long transfers must start on an even byte address.
    assign req_misal = (req_size != 2'b00) && req_addr[0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wlo_d   = wlo_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        byte_d  = byte_q;
        long_d  = long_q;
        half_d  = half_q;
        err_d   = err_q;
        misal_d = misal_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = req_rw;
                    byte_d  = (req_size == 2'b00);
                    long_d  = (req_size == 2'b10);
                    addr_d  = req_addr;
                    wlo_d   = req_wdata[15:0];
                    half_d  = 1'b0;
                    misal_d = req_misal;
                    err_d   = req_misal;
                    if (req_size == 2'b00)
                        dout_d = {req_wdata[7:0], req_wdata[7:0]};
                    else if (req_size == 2'b10)
                        dout_d = req_wdata[31:16];
                    else
                        dout_d = req_wdata[15:0];
                    state_d = req_misal ? S_END : S_ADDR;
                end
            end
            S_ADDR: state_d = S_STROBE;
            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (BERR) begin
                    err_d   = 1'b1;
                    state_d = S_END;
                end else if (DTACK) begin
                    if (rw_q) begin
                        if (byte_q)
                            rdata_d = {24'h0, addr_q[0] ? D_in[7:0] : D_in[15:8]};
                        else if (!long_q)
                            rdata_d = {16'h0, D_in};
                        else if (!half_q)
                            rdata_d = {D_in, 16'h0};
                        else
                            rdata_d = {rdata_q[31:16], D_in};
                    end
                    state_d = S_END;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END: begin
                if (long_q && !half_q && !err_q) begin
                    addr_d  = addr_q + ADDR_W'(2);
                    dout_d  = wlo_q;
                    half_d  = 1'b1;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            wlo_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b1;
            byte_q  <= 1'b0;
            long_q  <= 1'b0;
            half_q  <= 1'b0;
            err_q   <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wlo_q   <= wlo_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            byte_q  <= byte_d;
            long_q  <= long_d;
            half_q  <= half_d;
            err_q   <= err_d;
            misal_q <= misal_d;
        end
    end

    logic strobe;
    assign strobe = (state_q == S_STROBE) || (state_q == S_WAIT);

    assign busy  = (state_q != S_IDLE);
    assign AS    = strobe;
    assign UDS   = strobe && (!byte_q || !addr_q[0]);
    assign LDS   = strobe && (!byte_q || addr_q[0]);
    assign RW    = (state_q == S_IDLE) ? 1'b1 : rw_q;
    assign D_oe  = !rw_q && (strobe || ((state_q == S_END) && !misal_q));
    assign A     = addr_q[ADDR_W-1:1];
    assign D_out = dout_q;
    assign rdata = rdata_q;
    // END after an error-free first half of a long is an internal hop, not a completion.
    assign ack   = (state_q == S_END) && !(long_q && !half_q && !err_q);
    assign err   = ack && err_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Bench for bus_interface_unit: directed vector table plus randomized transactions
// checked against a transaction-level model, with a reactive bus slave.
module tb_bus_interface_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [1:0]  req_size = 2'b00;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ack, err, busy, AS, UDS, LDS, RW, D_oe;
    logic [31:0] rdata;
    logic [22:0] A;
    logic [15:0] D_out;
    logic [15:0] D_in = '0;
    logic        DTACK = 1'b0;
    logic        BERR = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    bus_interface_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(24)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_rw(req_rw), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .A(A), .D_out(D_out), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .D_oe(D_oe), .D_in(D_in), .DTACK(DTACK), .BERR(BERR)
    );

    always #5 CLK = ~CLK;

    // Slave response kinds per bus cycle: 0 DTACK, 1 BERR, 2 silent, 3 BERR with DTACK.
    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
        int          k0;
        int          n0;
        logic [15:0] d0;
        int          k1;
        int          n1;
        logic [15:0] d1;
        int          e_edges;
        logic        e_err;
        int          e_bus;
        logic        e_chkr;
        logic [31:0] e_rdata;
        logic [22:0] e_a0;
        logic [22:0] e_a1;
        logic        e_uds;
        logic        e_lds;
        logic [15:0] e_do0;
        logic [15:0] e_do1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction-level reference: latency, error and data from the transfer rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   misal = (v.size != 2'd0) && v.addr[0];
        bit   is_long = (v.size == 2'd2);
        bit   is_byte = (v.size == 2'd0);
        int   halves = is_long ? 2 : 1;
        int   kind, nw;
        logic [23:0] a2 = v.addr + 24'd2;
        r.e_edges = 0; r.e_err = 0; r.e_bus = 0;
        if (misal) begin
            r.e_edges = 1;
            r.e_err   = 1;
        end else begin
            for (int h = 0; h < halves; h++) begin
                kind = (h == 0) ? v.k0 : v.k1;
                nw   = (h == 0) ? v.n0 : v.n1;
                r.e_edges += 3 + ((kind == 2) ? TO : nw + 1);
                r.e_bus = h + 1;
                if (kind != 0) begin
                    r.e_err = 1;
                    break;
                end
            end
        end
        r.e_chkr = v.rw && !r.e_err;
        if (is_byte) r.e_rdata = {24'h0, v.addr[0] ? v.d0[7:0] : v.d0[15:8]};
        else if (is_long) r.e_rdata = {v.d0, v.d1};
        else r.e_rdata = {16'h0, v.d0};
        r.e_a0  = v.addr[23:1];
        r.e_a1  = a2[23:1];
        r.e_uds = !is_byte || !v.addr[0];
        r.e_lds = !is_byte || v.addr[0];
        if (is_byte) r.e_do0 = {v.wdata[7:0], v.wdata[7:0]};
        else if (is_long) r.e_do0 = v.wdata[31:16];
        else r.e_do0 = v.wdata[15:0];
        r.e_do1 = v.wdata[15:0];
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int edges = 0;
        int bus_n = 0;
        int cyc = 0;
        int kind, nw, h;
        bit got = 0;
        logic prev_as = 1'b0;
        logic a_err;
        logic [31:0] a_rdata;
        @(negedge CLK);
        req = 1'b1; req_rw = v.rw; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge CLK);
        edges = 1;
        @(negedge CLK);
        req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (AS && !prev_as) begin
                if (bus_n < 2) begin
                    chk({tag, ".A"}, A, (bus_n == 0) ? v.e_a0 : v.e_a1);
                    chk({tag, ".UDS"}, UDS, v.e_uds);
                    chk({tag, ".LDS"}, LDS, v.e_lds);
                    chk({tag, ".RW"}, RW, v.rw);
                    chk({tag, ".D_oe"}, D_oe, !v.rw);
                    if (!v.rw) chk({tag, ".D_out"}, D_out, (bus_n == 0) ? v.e_do0 : v.e_do1);
                end
                bus_n++;
                cyc = 0;
            end
            prev_as = AS;
            if (AS) begin
                cyc++;
                h    = (bus_n >= 2) ? 1 : 0;
                kind = (h == 0) ? v.k0 : v.k1;
                nw   = (h == 0) ? v.n0 : v.n1;
                D_in  = (h == 0) ? v.d0 : v.d1;
                DTACK = (kind == 0 || kind == 3) && (cyc >= 2 + nw);
                BERR  = (kind == 1 || kind == 3) && (cyc >= 2 + nw);
            end else begin
                DTACK = 1'b0;
                BERR  = 1'b0;
            end
            if (ack) begin
                got = 1;
                a_err = err;
                a_rdata = rdata;
                break;
            end
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        DTACK = 1'b0;
        BERR  = 1'b0;
        if (!got) begin
            chk({tag, ".ack_seen"}, 0, 1);
        end else begin
            chk({tag, ".latency"}, edges, v.e_edges);
            chk({tag, ".err"}, a_err, v.e_err);
            chk({tag, ".bus_cycles"}, bus_n, v.e_bus);
            if (v.e_chkr) chk({tag, ".rdata"}, a_rdata, v.e_rdata);
            @(negedge CLK);
            chk({tag, ".ack_pulse"}, {ack, busy}, 2'b00);
            if (v.e_chkr) chk({tag, ".rdata_held"}, rdata, v.e_rdata);
        end
    endtask

    vec_t tbl[9];
    vec_t rv;
    int   acks;

    initial begin
        tbl[0] = '{1'b1, 2'd1, 24'h000100, 32'h0, 0, 0, 16'hBEEF, 0, 0, 16'h0,
                   4, 1'b0, 1, 1'b1, 32'h0000BEEF, 23'h000080, 23'h0, 1'b1, 1'b1, 16'h0, 16'h0};
        tbl[1] = '{1'b0, 2'd0, 24'h000201, 32'h5A, 0, 2, 16'h0, 0, 0, 16'h0,
                   6, 1'b0, 1, 1'b0, 32'h0, 23'h000100, 23'h0, 1'b0, 1'b1, 16'h5A5A, 16'h0};
        tbl[2] = '{1'b1, 2'd2, 24'hFFFFFE, 32'h0, 0, 0, 16'h1234, 0, 0, 16'h5678,
                   8, 1'b0, 2, 1'b1, 32'h12345678, 23'h7FFFFF, 23'h0, 1'b1, 1'b1, 16'h0, 16'h0};
        tbl[3] = '{1'b1, 2'd2, 24'h000010, 32'h0, 3, 0, 16'h1111, 0, 0, 16'h2222,
                   4, 1'b1, 1, 1'b0, 32'h0, 23'h000008, 23'h000009, 1'b1, 1'b1, 16'h0, 16'h0};
        tbl[4] = '{1'b1, 2'd1, 24'h000003, 32'h0, 0, 0, 16'h0, 0, 0, 16'h0,
                   1, 1'b1, 0, 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b1, 16'h0, 16'h0};
        tbl[5] = '{1'b1, 2'd1, 24'h000040, 32'h0, 2, 0, 16'h0, 0, 0, 16'h0,
                   7, 1'b1, 1, 1'b0, 32'h0, 23'h000020, 23'h0, 1'b1, 1'b1, 16'h0, 16'h0};
        tbl[6] = '{1'b1, 2'd0, 24'h000400, 32'h0, 0, 0, 16'hA5C3, 0, 0, 16'h0,
                   4, 1'b0, 1, 1'b1, 32'h000000A5, 23'h000200, 23'h0, 1'b1, 1'b0, 16'h0, 16'h0};
        tbl[7] = '{1'b0, 2'd2, 24'h000020, 32'hCAFEF00D, 0, 0, 16'h0, 0, 1, 16'h0,
                   9, 1'b0, 2, 1'b0, 32'h0, 23'h000010, 23'h000011, 1'b1, 1'b1, 16'hCAFE, 16'hF00D};
        tbl[8] = '{1'b0, 2'd2, 24'h000100, 32'h89ABCDEF, 0, 0, 16'h0, 1, 1, 16'h0,
                   9, 1'b1, 2, 1'b0, 32'h0, 23'h000080, 23'h000081, 1'b1, 1'b1, 16'h89AB, 16'hCDEF};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        chk("reset.ctrl", {ack, err, busy, AS, UDS, LDS, D_oe, RW}, 8'b0000_0001);
        chk("reset.A", A, 23'h0);
        chk("reset.D_out", D_out, 16'h0);
        chk("reset.rdata", rdata, 32'h0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.rw    = $urandom_range(0, 1);
            rv.size  = 2'($urandom_range(0, 3));
            rv.addr  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                                   : 24'($urandom);
            rv.wdata = $urandom;
            rv.d0    = 16'($urandom);
            rv.d1    = 16'($urandom);
            rv.n0    = $urandom_range(0, 2);
            rv.n1    = $urandom_range(0, 2);
            rv.k0    = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            rv.k1    = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Reset while the slave withholds DTACK; the aborted cycle must never complete.
        @(negedge CLK);
        req = 1'b1; req_rw = 1'b1; req_size = 2'd1; req_addr = 24'h000100;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_wait.in_wait", {AS, busy}, 2'b11);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_wait.outputs", {AS, UDS, LDS, D_oe, busy, ack, err}, 7'b0);
        chk("rst_wait.RW", RW, 1'b1);
        RESET = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge CLK);
            if (ack) acks++;
        end
        chk("rst_wait.no_ack", acks, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
